ab_input_debounce: RTL and testbench

//   Input conditioner for the a/b control inputs of the Mealy FSM stage.

---
 rtl/ab_input_debounce_if.sv | 29 ++
 rtl/ab_input_debounce.sv | 116 +++++++++++
 tb/tb_ab_input_debounce.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ab_input_debounce_if.sv
// ============================================================================
// Module      : ab_input_debounce_if
// Description : Raw a/b inputs and their conditioned levels and edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ab_input_debounce_if;
  logic a_raw;
  logic b_raw;
  logic a;
  logic b;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;

  modport master (
    output a_raw, b_raw,
    input  a, b, a_rise, a_fall, b_rise, b_fall
  );

  modport slave (
    input  a_raw, b_raw,
    output a, b, a_rise, a_fall, b_rise, b_fall
  );
endinterface

`default_nettype wire

// File: rtl/ab_input_debounce.sv
// ============================================================================
// Module      : ab_input_debounce
// Description : 2-FF synchroniser plus debounce FSM per channel for inputs a/b,
//               giving a clean level and one-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ab_input_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  ab_input_debounce_if.slave    bus
);

  typedef enum logic [1:0] {
    LO_STABLE = 2'd0,
    WAIT_HI   = 2'd1,
    HI_STABLE = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [1:0] w_raw;
  assign w_raw = {bus.b_raw, bus.a_raw};

  // Channel 0 is a, channel 1 is b; the two are fully independent.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lvl;
    logic             r_rise;
    logic             r_fall;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_state <= LO_STABLE;
        r_cnt   <= '0;
        r_lvl   <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_s1   <= w_raw[g];
        r_s2   <= r_s1;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        case (r_state)
          LO_STABLE: begin
            if (r_s2) begin
              r_state <= WAIT_HI;
              r_cnt   <= c_cnt_one;
            end else begin
              r_cnt   <= '0;
            end
          end
          WAIT_HI: begin
            if (!r_s2) begin
              r_state <= LO_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == c_cnt_last) begin
              r_state <= HI_STABLE;
              r_lvl   <= 1'b1;
              r_rise  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= r_cnt + c_cnt_one;
            end
          end
          HI_STABLE: begin
            if (!r_s2) begin
              r_state <= WAIT_LO;
              r_cnt   <= c_cnt_one;
            end else begin
              r_cnt   <= '0;
            end
          end
          WAIT_LO: begin
            if (r_s2) begin
              r_state <= HI_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == c_cnt_last) begin
              r_state <= LO_STABLE;
              r_lvl   <= 1'b0;
              r_fall  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= r_cnt + c_cnt_one;
            end
          end
          default: begin
            r_state <= LO_STABLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.a      = g_ch[0].r_lvl;
  assign bus.a_rise = g_ch[0].r_rise;
  assign bus.a_fall = g_ch[0].r_fall;
  assign bus.b      = g_ch[1].r_lvl;
  assign bus.b_rise = g_ch[1].r_rise;
  assign bus.b_fall = g_ch[1].r_fall;

endmodule

`default_nettype wire

// File: tb/tb_ab_input_debounce.sv
// ============================================================================
// Module      : tb_ab_input_debounce
// Description : Scoreboard bench: run-length reference model vs. debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ab_input_debounce;

  localparam int DB_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ab_input_debounce_if bus ();

  ab_input_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (8)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  // Expected word: {b_fall, b_rise, b, a_fall, a_rise, a}
  logic [5:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int exp_rises = 0;
  int act_rises = 0;

  // Reference model: each raw input reaches the decision point two edges
  // late; the level flips once DB_CYCLES consecutive delayed samples disagree.
  initial begin
    int   m_dly[2][$];
    int   m_lvl[2];
    int   m_run[2];
    int   m_pr[2];
    int   m_pf[2];
    int   raw_v[2];
    int   smp;
    for (int c = 0; c < 2; c++) begin
      m_lvl[c] = 0;
      m_run[c] = 0;
      m_dly[c] = {0, 0};
    end
    forever begin
      @(posedge clk);
      raw_v[0] = int'(bus.a_raw);
      raw_v[1] = int'(bus.b_raw);
      for (int c = 0; c < 2; c++) begin
        m_pr[c] = 0;
        m_pf[c] = 0;
        if (rst) begin
          m_lvl[c] = 0;
          m_run[c] = 0;
          m_dly[c] = {0, 0};
        end else begin
          smp = m_dly[c].pop_front();
          m_dly[c].push_back(raw_v[c]);
          if (smp != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DB_CYCLES) begin
              m_lvl[c] = smp;
              m_run[c] = 0;
              if (smp == 1) m_pr[c] = 1; else m_pf[c] = 1;
            end
          end else begin
            m_run[c] = 0;
          end
        end
        exp_rises += m_pr[c];
      end
      exp_q.push_back({m_pf[1] != 0, m_pr[1] != 0, m_lvl[1] != 0,
                       m_pf[0] != 0, m_pr[0] != 0, m_lvl[0] != 0});
    end
  end

  // Monitor: every clock the DUT presents a fresh registered output word.
  initial begin
    logic [5:0] e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.b_fall, bus.b_rise, bus.b, bus.a_fall, bus.a_rise, bus.a};
        act_rises += int'(bus.a_rise === 1'b1) + int'(bus.b_rise === 1'b1);
        n_cmp++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t actual=%b expected=%b ({bf,br,b,af,ar,a})",
                   $time, act, e);
        end
      end
    end
  end

  task automatic hold(input logic va, input logic vb, input int n);
    bus.a_raw = va;
    bus.b_raw = vb;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst();
    #5 rst = 1'b1;
    @(negedge clk);
    #5 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int guard;
    bus.a_raw = 1'b1;
    bus.b_raw = 1'b1;
    // Reset held with raw inputs high, then release and keep them high.
    repeat (3) @(negedge clk);
    #5 rst = 1'b0;
    @(negedge clk);
    hold(1'b1, 1'b1, 10);
    // Both fall, then a 3-edge high run on a must be rejected.
    hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 10);
    // Rise then clean fall.
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    // Fall interrupted by a single high sample restarts the count.
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 3);
    hold(1'b1, 1'b0, 1);
    hold(1'b0, 1'b0, 10);
    // a held high while b glitches for 2 edges.
    hold(1'b1, 1'b1, 2);
    hold(1'b1, 1'b0, 10);
    // Reset while a is mid-debounce, raw held high through release.
    hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 4);
    pulse_rst();
    hold(1'b1, 1'b0, 10);
    // Randomized run lengths straddling the debounce threshold.
    for (int i = 0; i < 400; i++) begin
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(1, 8)));
      if ($urandom_range(0, 99) == 0) pulse_rst();
    end
    hold(1'b0, 1'b0, 12);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending expected=0 pending", exp_q.size());
    end
    n_cmp++;
    if (act_rises != exp_rises) begin
      n_fail++;
      $display("FAIL rise_count actual=%0d required=%0d", act_rises, exp_rises);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
